// File: rtl/alu_pkg.sv
// Shared opcode encodings, sizes and FSM state type for the 8-bit ALU and its command sequencer.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int ADDR_W = 2;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SHR   = 4'b0010;
    localparam logic [3:0] OP_SHL   = 4'b0011;
    localparam logic [3:0] OP_ROR   = 4'b0100;
    localparam logic [3:0] OP_ROL   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_LOADI = 4'b1110;
    localparam logic [3:0] OP_READ  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_reserved(input logic [3:0] op);
        return (op >= 4'b1010) && (op <= 4'b1101);
    endfunction

    function automatic logic is_rotate(input logic [3:0] op);
        return (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port, async active-low clear.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 8-bit ALU: reads operands from the register file, issues them to the
// ALU, writes the result back and returns it over a response handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [1:0]  cmd_rd,
    input  logic [1:0]  cmd_rs1,
    input  logic [1:0]  cmd_rs2,
    input  logic [7:0]  cmd_imm,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_instr,
    input  logic [7:0]  alu_f,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // A producer holding valid keeps its payload stable until that edge; ready never depends
    // combinationally on valid on either interface.

    state_t state_q, state_d;

    logic [3:0]        op_q;
    logic [1:0]        rd_q;
    logic [1:0]        rs1_q;
    logic [7:0]        imm_q;

    logic              accept;
    logic              wb_en;
    logic [7:0]        wb_data;
    logic [7:0]        rsp_data_d;
    logic [1:0]        raddr1;
    logic [7:0]        rdata1;
    logic [7:0]        rdata2;

    // Port 1 serves the operand read at accept and the READ result in WB.
    assign raddr1 = (state_q == IDLE) ? cmd_rs1 : rs1_q;

    alu_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (cmd_rs2),
        .rdata2 (rdata2),
        .we     (wb_en),
        .waddr  (rd_q),
        .wdata  (wb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        wb_en      = 1'b0;
        wb_data    = '0;
        rsp_data_d = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WB;
            end
            WB: begin
                state_d = RESP;
                if (is_alu_op(op_q)) begin
                    wb_en      = 1'b1;
                    wb_data    = alu_f;
                    rsp_data_d = alu_f;
                end else if (op_q == OP_LOADI) begin
                    wb_en      = 1'b1;
                    wb_data    = imm_q;
                    rsp_data_d = imm_q;
                end else if (op_q == OP_READ) begin
                    rsp_data_d = rdata1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            imm_q <= cmd_imm;
        end
    end

    // ALU inputs move only for ALU ops; LOADI, READ and reserved commands leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_instr <= '0;
        end else if (accept && is_alu_op(cmd_op)) begin
            alu_a     <= rdata1;
            alu_b     <= is_rotate(cmd_op) ? (rdata2 & 8'h07) : rdata2;
            alu_instr <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (state_q == WB) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rsp_data_d;
            rsp_err   <= is_reserved(op_q);
        end else if (state_q == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_instr;
    logic [7:0] alu_f;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [1:0] dbg_state;

    logic [8:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_instr (alu_instr),
        .alu_f     (alu_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // Behavioural stand-in for the combinational ALU.
    logic [15:0] rot_r, rot_l;
    always_comb begin
        rot_r = {alu_a, alu_a} >> alu_b[2:0];
        rot_l = {alu_a, alu_a} << alu_b[2:0];
        alu_f = 8'h00;
        case (alu_instr)
            4'b0000: alu_f = alu_a + alu_b;
            4'b0001: alu_f = alu_a - alu_b;
            4'b0010: alu_f = (alu_b >= 8) ? 8'h00 : (alu_a >> alu_b);
            4'b0011: alu_f = (alu_b >= 8) ? 8'h00 : (alu_a << alu_b);
            4'b0100: alu_f = rot_r[7:0];
            4'b0101: alu_f = rot_l[15:8];
            4'b0110: alu_f = alu_a & alu_b;
            4'b0111: alu_f = alu_a | alu_b;
            4'b1000: alu_f = ~alu_a;
            4'b1001: alu_f = alu_a ^ alu_b;
            default: alu_f = 8'h00;
        endcase
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per completed response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {7'd0, rsp_err, rsp_data}, 16'hFFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rsp", {7'd0, rsp_err, rsp_data}, {7'd0, e});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm, input logic exp_err,
                        input logic [7:0] exp_data, input bit push, output int waits);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        if (push) exp_q.push_back({exp_err, exp_data});
        waits = 0;
        while (!cmd_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 40) begin
            check("accept_timeout", 16'd0, 16'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            // Post-accept garbage on the command bus must be ignored.
            cmd_valid = 1'b0;
            cmd_op    = 4'($urandom_range(0, 15));
            cmd_rd    = 2'($urandom_range(0, 3));
            cmd_rs1   = 2'($urandom_range(0, 3));
            cmd_rs2   = 2'($urandom_range(0, 3));
            cmd_imm   = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("done_timeout", 16'd0, 16'd1);
    endtask

    task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, input logic exp_err,
                       input logic [7:0] exp_data);
        int w;
        send(op, rd, rs1, rs2, imm, exp_err, exp_data, 1'b1, w);
        wait_done();
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        cmd_imm   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("rst_rsp", {7'd0, rsp_err, rsp_data}, 16'd0);
        check("rst_alu", {alu_instr, alu_a, alu_b[3:0]}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cleared register file
        run(4'hF, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 8'h00);

        // LOADI / ADD with latency check
        run(4'hE, 2'd0, 2'd0, 2'd0, 8'h3C, 1'b0, 8'h3C);
        run(4'hE, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, 8'h05);
        check("loadi_keeps_alu", {alu_instr, alu_a, 4'h0}, 16'h0000);
        send(4'h0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, 8'h41, 1'b1, w);
        @(posedge clk);
        #1;
        check("lat_edge2_no_valid", {15'd0, rsp_valid}, 16'd0);
        check("lat_edge2_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        @(posedge clk);
        #1;
        check("lat_edge3_valid", {15'd0, rsp_valid}, 16'd1);
        wait_done();
        run(4'hF, 2'd0, 2'd2, 2'd0, 8'h00, 1'b0, 8'h41);

        // SUB wrap, ADD wrap
        run(4'hE, 2'd0, 2'd0, 2'd0, 8'h03, 1'b0, 8'h03);
        run(4'hE, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0, 8'h05);
        run(4'h1, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, 8'hFE);
        run(4'hF, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 8'hFE);
        run(4'hE, 2'd0, 2'd0, 2'd0, 8'hF0, 1'b0, 8'hF0);
        run(4'hE, 2'd1, 2'd0, 2'd0, 8'h20, 1'b0, 8'h20);
        run(4'h0, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, 8'h10);

        // Rotate masks B, shift does not
        run(4'hE, 2'd0, 2'd0, 2'd0, 8'h81, 1'b0, 8'h81);
        run(4'hE, 2'd1, 2'd0, 2'd0, 8'h09, 1'b0, 8'h09);
        send(4'h4, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, 8'hC0, 1'b1, w);
        check("ror_alu_b_masked", {8'h00, alu_b}, 16'h0001);
        check("ror_alu_a", {8'h00, alu_a}, 16'h0081);
        check("ror_alu_instr", {12'h000, alu_instr}, 16'h0004);
        wait_done();
        send(4'h2, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b1, w);
        check("shr_alu_b_unmasked", {8'h00, alu_b}, 16'h0009);
        wait_done();
        // rd == rs1 uses the old R0
        run(4'h0, 2'd0, 2'd0, 2'd1, 8'h00, 1'b0, 8'h8A);
        run(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h8A);

        // Backpressure: XOR 8A ^ 09 = 83
        @(negedge clk);
        rsp_ready = 1'b0;
        send(4'h9, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, 8'h83, 1'b1, w);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {15'd0, rsp_valid}, 16'd1);
            check("bp_data", {8'h00, rsp_data}, 16'h0083);
            check("bp_cmd_ready", {15'd0, cmd_ready}, 16'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_hs", {15'd0, cmd_ready}, 16'd1);
        send(4'hF, 2'd0, 2'd3, 2'd0, 8'h00, 1'b0, 8'h83, 1'b1, w);
        check("bp_next_accept_wait", w[15:0], 16'd0);
        wait_done();

        // Reserved opcode leaves registers and ALU inputs alone
        run(4'hB, 2'd2, 2'd0, 2'd1, 8'h55, 1'b1, 8'h00);
        check("rsvd_keeps_alu_instr", {12'h000, alu_instr}, 16'h0009);
        run(4'hF, 2'd0, 2'd2, 2'd0, 8'h00, 1'b0, 8'hC0);
        run(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h8A);

        // Reset during WB of ADD rd=1 (would write 8A+09=93)
        send(4'h0, 2'd1, 2'd0, 2'd1, 8'h00, 1'b0, 8'h93, 1'b0, w);
        @(posedge clk);
        #1;
        check("pre_rst_state_wb", {14'd0, dbg_state}, 16'd2);
        rst_n = 1'b0;
        #1;
        check("in_rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        check("in_rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_valid", {15'd0, rsp_valid}, 16'd0);
            @(posedge clk);
            #1;
        end
        run(4'hF, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0, 8'h00);
        run(4'hF, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 8'h00);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the 8-bit combinational ALU. It accepts register-addressed commands over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU's A/B/Instruction inputs, captures the returned F into the destination register, and reports the result over a second valid/ready handshake. It sits between the instruction source (bench, UART bridge or microcontroller) and the ALU.

## Interface
- DATA_W, 8, operand/result width; fixed at 8 to match the ALU.
- NREGS, 4, register-file depth; the address width is 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode: 0000–1001 are ALU ops (ALU encoding); 1110 is LOADI; 1111 is READ; 1010–1101 are reserved.
- cmd_rd  in  2  destination register.
- cmd_rs1  in  2  source register for A.
- cmd_rs2  in  2  source register for B.
- cmd_imm  in  8  immediate for LOADI.
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_instr  out  4  registered ALU instruction.
- alu_f  in  8  ALU result; combinational from alu_a/alu_b/alu_instr.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  8  result value.
- rsp_err  out  1  set when the command used a reserved opcode.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: one cycle in which the ALU settles.
  - WB: writeback.
  - RESP: rsp_valid=1.
- IDLE → ISSUE on cmd_valid&&cmd_ready. In this cycle the sequencer latches op/rd and loads alu_a=R[rs1], alu_b=R[rs2], alu_instr=op.
- Rotates (0100, 0101): alu_b = R[rs2] & 8'h07. The ALU is only defined for rotate amounts below 8.
- Shifts (0010, 0011): B is passed unmasked. B ≥ 8 yields 0 from the ALU.
- NOT (1000): alu_b is driven with R[rs2] and is ignored by the ALU.
- ISSUE → WB unconditionally.
- WB → RESP:
  - ALU ops: R[rd] ← alu_f; rsp_data ← alu_f.
  - LOADI: R[rd] ← cmd_imm; rsp_data ← cmd_imm. The ALU outputs are not updated.
  - READ: rsp_data ← R[rs1]. No register write.
  - Reserved: no register write; rsp_data ← 0; rsp_err ← 1.
- RESP → IDLE on rsp_ready.
- rsp_data/rsp_err hold stable while rsp_valid=1 && !rsp_ready.
- Add/sub wrap modulo 256; no carry or borrow is reported.
- rd==rs1 or rd==rs2: operands are read before the write, so the old values are used.
- cmd_* inputs are sampled only on the accepting edge; later changes are ignored.

## Timing
- Reset value of every output and register is 0: R[0..3], alu_a, alu_b, alu_instr, rsp_valid, rsp_data, rsp_err. Exception: cmd_ready=1 in reset because the state is IDLE.
- Latency: rsp_valid rises 3 edges after the accepting edge (ISSUE, WB, RESP).
- With rsp_ready held high, throughput is one command per 4 cycles.
- cmd_ready is 0 in ISSUE, WB and RESP. There is no command buffering.
- rsp_valid is registered, not combinational from rsp_ready.
- Reset asserted mid-command: return immediately to IDLE. The pending command is dropped, the register file is cleared, and no response is issued.
- alu_a/alu_b/alu_instr change only on the accepting edge and otherwise hold their last values.

## Structure
- Package alu_pkg: DATA_W; opcode localparams (OP_ADD … OP_XOR, OP_LOADI, OP_READ); state enum {IDLE, ISSUE, WB, RESP}; is_reserved/is_rotate helper functions.
- The sequencer shares alu_pkg opcodes with the ALU so encodings cannot diverge.
- Sub-module alu_regfile: 4×8, two asynchronous read ports, one synchronous write port, asynchronous active-low clear.
- The FSM and handshakes stay in alu_cmd_sequencer. The bench instantiates the ALU alongside the sequencer.

## Test plan
- LOADI R0=8'h3C, LOADI R1=8'h05, then ADD rd=2,rs1=0,rs2=1 → rsp_data=8'h41, R2=8'h41, rsp_valid 3 cycles after accept.
- R0=8'h03, R1=8'h05, SUB rd=3 → rsp_data=8'hFE (wrap); R0=8'hF0, R1=8'h20, ADD → 8'h10.
- R0=8'h81, R1=8'h09, ROR (0100) → B masked to 1, rsp_data=8'hC0; SHR (0010) with B=9 → 8'h00.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0 throughout; the next command is accepted the cycle after the rsp handshake.
- Reserved opcode 1011 → rsp_err=1, rsp_data=0, all registers unchanged; READ rs1=2 afterwards returns the prior R2.
- Assert rst_n low during WB of ADD rd=1 → R1=0, rsp_valid never rises, cmd_ready=1 on the first cycle after release.
